// File: rtl/envelope_bank.sv
// Multi-channel envelope follower. It rectifies each channel and applies a one-pole
// attack/release smoother through one shared multiplier, one channel per cycle.
module envelope_bank #(
  parameter int NUM_CH = 8,
  parameter int WIDTH  = 24,
  parameter int SHIFT  = 20
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_CH*WIDTH-1:0]   samples_in,
  input  logic                      sample_valid_in,
  input  logic [SHIFT:0]            attack_in,
  input  logic [SHIFT:0]            release_in,
  input  logic                      overrun_clr_in,
  output logic [NUM_CH*WIDTH-1:0]   env_out,
  output logic                      env_valid_out,
  output logic                      busy_out,
  output logic                      overrun_out
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW   = WIDTH + SHIFT + 2;

  localparam logic [SHIFT:0]                ONE      = {1'b1, {SHIFT{1'b0}}};
  localparam logic [WIDTH-1:0]              POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]              NEG_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH+1:0]       SUM_MAX  = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic [CH_W-1:0]               LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, next_state;

  logic [CH_W-1:0]  ch;
  logic [SHIFT:0]   att_q, rel_q;
  logic [WIDTH-1:0] samp_q  [NUM_CH];
  logic [WIDTH-1:0] env_mem [NUM_CH];

  logic load, step, publish, drop;

  logic [WIDTH-1:0]        x, rect, env_cur, env_new;
  logic signed [WIDTH:0]   d;
  logic [SHIFT:0]          k;
  logic signed [PW-1:0]    d_ext, k_ext, p;
  logic signed [WIDTH+1:0] delta, sum;

  function automatic logic [SHIFT:0] clamp_coef(input logic [SHIFT:0] c);
    return (c > ONE) ? ONE : c;
  endfunction

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (sample_valid_in) next_state = RUN;
      RUN:     if (ch == LAST_CH)   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    load    = (state == IDLE) && sample_valid_in;
    step    = (state == RUN);
    publish = (state == DONE);
    drop    = (state != IDLE) && sample_valid_in;
  end

  // Shared datapath for the channel selected by ch
  always_comb begin
    x       = samp_q[ch];
    env_cur = env_mem[ch];
    if (x == NEG_MIN)     rect = POS_MAX;
    else if (x[WIDTH-1])  rect = ~x + WIDTH'(1);
    else                  rect = x;
    d     = {1'b0, rect} - {1'b0, env_cur};
    k     = (rect > env_cur) ? att_q : rel_q;
    d_ext = PW'(d);
    k_ext = PW'(k);
    p     = d_ext * k_ext;
    delta = (WIDTH+2)'(p >>> SHIFT);
    sum   = $signed({2'b00, env_cur}) + delta;
    // The update cannot leave [0, POS_MAX] mathematically; the clamp guards it anyway.
    if (sum[WIDTH+1])       env_new = '0;
    else if (sum > SUM_MAX) env_new = POS_MAX;
    else                    env_new = sum[WIDTH-1:0];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ch            <= '0;
      att_q         <= '0;
      rel_q         <= '0;
      env_out       <= '0;
      env_valid_out <= 1'b0;
      busy_out      <= 1'b0;
      overrun_out   <= 1'b0;
      // NOTE: the envelope memory is reset because the filter state must start from zero;
      // the sample latch is cleared alongside it so no X can reach the datapath.
      for (int c = 0; c < NUM_CH; c++) begin
        env_mem[c] <= '0;
        samp_q[c]  <= '0;
      end
    end else begin
      env_valid_out <= publish;
      busy_out      <= (next_state != IDLE);

      if (drop)                overrun_out <= 1'b1;
      else if (overrun_clr_in) overrun_out <= 1'b0;

      if (load) begin
        ch    <= '0;
        att_q <= clamp_coef(attack_in);
        rel_q <= clamp_coef(release_in);
        for (int c = 0; c < NUM_CH; c++) samp_q[c] <= samples_in[c*WIDTH +: WIDTH];
      end

      if (step) begin
        env_mem[ch] <= env_new;
        ch          <= ch + CH_W'(1);
      end

      if (publish) begin
        for (int c = 0; c < NUM_CH; c++) env_out[c*WIDTH +: WIDTH] <= env_mem[c];
      end
    end
  end

endmodule

// File: doc/envelope_bank.md
Name: envelope_bank

Overview:
Multi-channel envelope follower for the vocoder analysis path. It takes one frame of NUM_CH band-filtered samples, full-wave rectifies each one, and smooths it with a one-pole filter that has separate attack and release coefficients. One shared multiply datapath serves all channels, time-multiplexed one channel per cycle, so the band count scales without duplicating filters. Its output envelopes drive the synthesis-side channel gains.

Parameters:
NUM_CH, 8, number of channels (>=1)
WIDTH, 24, signed sample width
SHIFT, 20, fractional bits of the coefficients; a coefficient of 2^SHIFT equals 1.0

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-high
samples_in  input  NUM_CH*WIDTH  signed samples; channel c occupies bits [c*WIDTH +: WIDTH]
sample_valid_in  input  1  one-cycle strobe; frame is present on samples_in
attack_in  input  SHIFT+1  unsigned attack coefficient; values above 2^SHIFT are treated as 2^SHIFT
release_in  input  SHIFT+1  unsigned release coefficient; same clamp
overrun_clr_in  input  1  clears overrun_out
env_out  output  NUM_CH*WIDTH  signed envelopes, always >= 0, same packing as samples_in
env_valid_out  output  1  one-cycle pulse when env_out updates
busy_out  output  1  high while a frame is in process
overrun_out  output  1  sticky flag: a frame was dropped

Behaviour:
- Reset, asynchronous: state=IDLE; env_out, internal envelope memory, channel counter, env_valid_out, busy_out and overrun_out all go to 0. A reset mid-frame abandons the frame; no partial env_out update is produced.
- FSM has three states: IDLE, RUN, DONE. busy_out = (state != IDLE), registered.
- IDLE: on sample_valid_in, latch samples_in, attack_in and release_in (both clamped to 2^SHIFT); set ch=0; go to RUN. Coefficient changes mid-frame have no effect.
- RUN: one channel per cycle, ch from 0 to NUM_CH-1.
  - rect = |x|. The most negative value, -2^(WIDTH-1), saturates to 2^(WIDTH-1)-1.
  - d = rect - env[ch], computed at WIDTH+1 bits signed.
  - k = attack when rect > env[ch], otherwise release.
  - p = d * k, computed at full width (WIDTH+SHIFT+2 bits signed).
  - env[ch] <= env[ch] + (p >>> SHIFT), using an arithmetic shift (floor).
  - The result always lies in [0, 2^(WIDTH-1)-1]. The implementation must still clamp to that range, defensively.
  - After ch = NUM_CH-1, go to DONE.
- DONE, one cycle: copy every env[] to env_out, pulse env_valid_out high for this cycle, return to IDLE.
- Latency: if the strobe is sampled at edge E, env_valid_out is high for the cycle following edge E+NUM_CH+1. The frame period must be at least NUM_CH+2 cycles.
- env_out holds its value between pulses. Channels never interact.
- sample_valid_in while in RUN or DONE: the frame is dropped and overrun_out is set. The frame in progress is unaffected.
- overrun_clr_in clears overrun_out. If it coincides with a new drop, set wins.
- sample_valid_in in the same cycle as DONE→IDLE: dropped, because the state is not yet IDLE.
- k=0 (attack or release): the envelope holds. k=2^SHIFT: the envelope jumps to rect exactly.

Test Plan:
- Reset, then idle: env_out=0, busy_out=0, env_valid_out=0, overrun_out=0. Assert rst_in mid-RUN → all outputs 0 within the same cycle, and no env_valid_out pulse afterwards.
- attack=2^20, release=2^19, ch0=-1000, others 0 → env ch0=1000, others 0. Next frames with all 0 → ch0=500, then 250. env_valid_out pulses exactly NUM_CH+2 cycles after the strobe (10 for NUM_CH=8).
- ch3=-8388608, attack=2^20 → env ch3=8388607. Then attack=2^19 with ch3=+8388607 → stays 8388607.
- Floor check: env=1, input 0, release=2^19 → env=0, never negative. Attack=0, input 5000 from env=0 → stays 0. attack_in=2^21-1 (clamped) with input 7 → env=7.
- Strobe again 3 cycles after a strobe → overrun_out=1, second frame ignored (env matches the first frame only). overrun_clr_in → 0. Strobe and clear in the same cycle while busy → overrun_out=1.
- Back-to-back strobes at exactly NUM_CH+2-cycle spacing, 100 random frames → matches a bit-true reference model, no overruns.
